seg_digit_sequencer: RTL and testbench



---
 rtl/seg_pkg.sv | 35 +++
 rtl/hex_to_seg7.sv | 13 +
 rtl/seg_digit_sequencer.sv | 173 +++++++++++++++++
 tb/tb_seg_digit_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment digit sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex font, bit order gfedcba, active high.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // Index of the most significant non-zero hex digit; 0 for an all-zero value,
    // so a zero value still shows a single "0".
    function automatic int highest_nonzero_digit(input logic [31:0] value, input int digits);
        int pos;
        pos = 0;
        for (int d = 0; d < 8; d++) begin
            if (d < digits && value[d*4 +: 4] != 4'h0) begin
                pos = d;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex digit to 7-segment pattern decoder (gfedcba).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_FONT[i_nibble];

endmodule

// File: rtl/seg_digit_sequencer.sv
// Shows a loaded hex value one digit at a time (MSB first) on a 7-segment display,
// each digit held DWELL cycles then blanked GAP cycles; optional repeat.
// Latency: first digit on the cycle after load acceptance; all outputs registered.
// Backpressure: load_ready high in IDLE (and in the last digit's gap while repeating);
// loads offered while load_ready is low are dropped, not queued.
// Build option SEG_LEADING_ZERO_BLANK_EN: skip leading zero digits.
module seg_digit_sequencer
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 100,
    parameter int GAP    = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic                  load_ready,
    input  logic                  repeat_en,
    input  logic                  stop,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic                  busy,
    output logic                  done
);

    localparam int IW   = $clog2(DIGITS);
    localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [IW-1:0] IDX_MSB    = IW'(DIGITS - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_start;
    logic [4*DIGITS-1:0]   r_val;
    logic [CW-1:0]         r_cnt;
    logic [6:0]            r_segments;
    logic                  r_dp;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_load_ready;

    state_t                w_nxt_state;
    logic [IW-1:0]         w_nxt_idx;
    logic [IW-1:0]         w_nxt_start;
    logic [4*DIGITS-1:0]   w_nxt_val;
    logic [CW-1:0]         w_nxt_cnt;
    logic                  w_nxt_done;
    logic                  w_step;
    logic                  w_accept;
    logic [IW-1:0]         w_load_start;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg;

    assign w_accept = load_valid & r_load_ready;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign w_load_start = IW'(highest_nonzero_digit(32'(load_data), DIGITS));
`else
    assign w_load_start = IDX_MSB;
`endif

    // Next-state evaluation: dwell/gap timing, digit stepping, repeat and reload.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_start = r_start;
        w_nxt_val   = r_val;
        w_nxt_cnt   = r_cnt;
        w_nxt_done  = 1'b0;
        w_step      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_nxt_state = ST_IDLE;
            end
            ST_SHOW: begin
                if (r_cnt == DWELL_LAST) begin
                    if (GAP == 0) begin
                        w_step = 1'b1;
                    end else begin
                        w_nxt_state = ST_GAP;
                        w_nxt_cnt   = '0;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_step = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // End of one digit's slot: next digit, wrap for repeat, or finish.
        if (w_step) begin
            w_nxt_cnt = '0;
            if (r_idx != '0) begin
                w_nxt_idx   = r_idx - 1'b1;
                w_nxt_state = ST_SHOW;
            end else if (repeat_en) begin
                w_nxt_idx   = r_start;
                w_nxt_state = ST_SHOW;
            end else begin
                w_nxt_state = ST_IDLE;
                w_nxt_done  = 1'b1;
            end
        end

        // A load (only possible in IDLE or the repeating final gap) overrides
        // the step, so a reload never produces a done pulse.
        if (w_accept) begin
            w_nxt_val   = load_data;
            w_nxt_start = w_load_start;
            w_nxt_idx   = w_load_start;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_SHOW;
            w_nxt_done  = 1'b0;
        end
    end

    assign w_digit = w_nxt_val[{w_nxt_idx, 2'b00} +: 4];

    hex_to_seg7 u_font (
        .i_nibble (w_digit),
        .o_seg    (w_seg)
    );

    // State register with outputs registered from the next state; reset and
    // stop both return to idle and discard the latched value.
    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_start      <= '0;
            r_val        <= '0;
            r_cnt        <= '0;
            r_segments   <= SEG_BLANK;
            r_dp         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_start      <= w_nxt_start;
            r_val        <= w_nxt_val;
            r_cnt        <= w_nxt_cnt;
            r_segments   <= (w_nxt_state == ST_SHOW) ? w_seg : SEG_BLANK;
            r_dp         <= (w_nxt_state == ST_SHOW) && (w_nxt_idx == '0);
            r_busy       <= (w_nxt_state != ST_IDLE);
            r_done       <= w_nxt_done;
            r_load_ready <= (w_nxt_state == ST_IDLE) ||
                            ((w_nxt_state == ST_GAP) && (w_nxt_idx == '0) && repeat_en);
        end
    end

    assign segments   = r_segments;
    assign dp         = r_dp;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule

// File: tb/tb_seg_digit_sequencer.sv
// Self-checking bench for seg_digit_sequencer (DIGITS=4, DWELL=4, GAP=2).
// Expected traces come from hand tables and from a digit-list model of the display.
// Honours SEG_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seg_digit_sequencer;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;
    localparam int GAP    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        repeat_en;
    logic        stop;
    logic [6:0]  segments;
    logic        dp;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    seg_digit_sequencer #(
        .DIGITS (DIGITS),
        .DWELL  (DWELL),
        .GAP    (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .repeat_en  (repeat_en),
        .stop       (stop),
        .segments   (segments),
        .dp         (dp),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic       busy;
        logic       done;
        logic       rdy;
    } obs_t;

    typedef struct {
        logic [15:0] val;
        int          n;
        logic [6:0]  s [4];
    } vec_t;

    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam obs_t IDLE_OBS = '{seg: 7'h00, dp: 1'b0, busy: 1'b0, done: 1'b0, rdy: 1'b1};

    obs_t       exp_q [$];
    logic [6:0] seg_q [$];
    int         checks   = 0;
    int         failures = 0;

    function automatic obs_t act();
        return obs_t'({segments, dp, busy, done, load_ready});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_obs(input string name, input int cyc, input obs_t e);
        obs_t a;
        a = act();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got seg=%h dp=%b busy=%b done=%b rdy=%b want seg=%h dp=%b busy=%b done=%b rdy=%b",
                     name, cyc, a.seg, a.dp, a.busy, a.done, a.rdy, e.seg, e.dp, e.busy, e.done, e.rdy);
        end
    endtask

    // Digits the display should show for value v, most significant first.
    function automatic void model_segs(input logic [15:0] v);
        int start;
        seg_q.delete();
        start = DIGITS - 1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        start = 0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] != 4'h0) start = d;
        end
`endif
        for (int d = start; d >= 0; d--) begin
            seg_q.push_back(FONT[v[4*d +: 4]]);
        end
    endfunction

    // Per-cycle observation trace for the digit list in seg_q.
    function automatic void build(input bit rep);
        bit last;
        exp_q.delete();
        for (int k = 0; k < seg_q.size(); k++) begin
            last = (k == seg_q.size() - 1);
            for (int c = 0; c < DWELL; c++)
                exp_q.push_back('{seg: seg_q[k], dp: last, busy: 1'b1, done: 1'b0, rdy: 1'b0});
            for (int c = 0; c < GAP; c++)
                exp_q.push_back('{seg: 7'h00, dp: 1'b0, busy: 1'b1, done: 1'b0, rdy: rep && last});
        end
        if (!rep) begin
            exp_q.push_back('{seg: 7'h00, dp: 1'b0, busy: 1'b0, done: 1'b1, rdy: 1'b1});
            exp_q.push_back(IDLE_OBS);
        end
    endfunction

    task automatic expect_trace(input string name, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            chk_obs(name, i, exp_q[i]);
            if (i < to) tick();
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load_data  = v;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    vec_t        tbl [5];
    logic [15:0] rv;
    int          stop_at;
    int          len;

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat_en  = 1'b0;
        stop       = 1'b0;

        tbl[0] = '{16'h1A2F, 4, '{7'h06, 7'h77, 7'h5B, 7'h71}};
        tbl[2] = '{16'h8E3C, 4, '{7'h7F, 7'h79, 7'h4F, 7'h39}};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        tbl[1] = '{16'h0000, 1, '{7'h3F, 7'h00, 7'h00, 7'h00}};
        tbl[3] = '{16'h00C5, 2, '{7'h39, 7'h6D, 7'h00, 7'h00}};
        tbl[4] = '{16'h0B07, 3, '{7'h7C, 7'h3F, 7'h07, 7'h00}};
`else
        tbl[1] = '{16'h0000, 4, '{7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tbl[3] = '{16'h00C5, 4, '{7'h3F, 7'h3F, 7'h39, 7'h6D}};
        tbl[4] = '{16'h0B07, 4, '{7'h3F, 7'h7C, 7'h3F, 7'h07}};
`endif

        // Reset state
        tick();
        tick();
        chk_obs("reset", 0, IDLE_OBS);
        rst_n = 1'b1;
        tick();
        chk_obs("post_reset", 0, IDLE_OBS);

        // Table vectors with hand-written digit patterns
        for (int t = 0; t < 5; t++) begin
            seg_q.delete();
            for (int k = 0; k < tbl[t].n; k++) seg_q.push_back(tbl[t].s[k]);
            build(1'b0);
            do_load(tbl[t].val);
            expect_trace($sformatf("vec%0d", t), 0, exp_q.size() - 1);
        end

        // Repeat: two full passes with no done, then reload during the final gap
        repeat_en = 1'b1;
        model_segs(16'h00C5);
        build(1'b1);
        len = exp_q.size();
        do_load(16'h00C5);
        expect_trace("rep_pass1", 0, len - 1);
        tick();
        expect_trace("rep_pass2", 0, len - 2);
        load_data  = 16'h1234;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat_en  = 1'b0;
        model_segs(16'h1234);
        build(1'b0);
        chk_obs("reload_first", 0, '{seg: 7'h06, dp: 1'b0, busy: 1'b1, done: 1'b0, rdy: 1'b0});
        expect_trace("reload", 0, exp_q.size() - 1);

        // Stop on the second cycle of digit index 2
        model_segs(16'h1A2F);
        build(1'b0);
        do_load(16'h1A2F);
        expect_trace("pre_stop", 0, 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_obs("stop", 0, IDLE_OBS);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_obs("stop_hold", i, IDLE_OBS);
        end
        stop       = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1A2F;
        tick();
        stop       = 1'b0;
        load_valid = 1'b0;
        chk_obs("stop_vs_load", 0, IDLE_OBS);
        tick();
        chk_obs("stop_vs_load", 1, IDLE_OBS);

        // Reset mid-SHOW
        do_load(16'h8E3C);
        model_segs(16'h8E3C);
        build(1'b0);
        expect_trace("pre_rst", 0, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_obs("rst_mid", 0, IDLE_OBS);
        tick();
        chk_obs("rst_mid", 1, IDLE_OBS);

        // load_valid while busy is ignored
        model_segs(16'h1A2F);
        build(1'b0);
        do_load(16'h1A2F);
        expect_trace("busy_load", 0, 2);
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        tick();
        load_valid = 1'b0;
        expect_trace("busy_load", 3, exp_q.size() - 1);

        // Randomized loads, stray loads while busy, random stops
        for (int r = 0; r < 25; r++) begin
            rv = 16'($urandom);
            if (r % 3 == 1) rv = rv & 16'h00FF;
            if (r % 4 == 2) rv = rv & 16'h0F0F;
            if (r == 7) rv = 16'h0000;
            model_segs(rv);
            build(1'b0);
            stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_q.size() - 3)) : -1;
            do_load(rv);
            for (int i = 0; i < exp_q.size(); i++) begin
                chk_obs("rand", i, exp_q[i]);
                if (i == stop_at) begin
                    stop = 1'b1;
                    tick();
                    stop = 1'b0;
                    chk_obs("rand_stop", i, IDLE_OBS);
                    break;
                end
                if (i < exp_q.size() - 1) begin
                    if (exp_q[i].rdy == 1'b0 && $urandom_range(0, 3) == 0) begin
                        load_valid = 1'b1;
                        load_data  = 16'($urandom);
                    end
                    tick();
                    load_valid = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
